// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch sequencer.
// Reads program bytes at the external PC, assembles 1- or 2-byte instructions,
// steers the PC (increment / branch load) and hands each complete instruction
// to the decoder over a valid/ready handshake. A HALT opcode parks the unit
// until a branch redirect or reset.
module fetch_unit #(
    parameter int unsigned       ADDR_W   = 8,
    parameter int unsigned       DATA_W   = 8,
    parameter int unsigned       LONG_BIT = 7,
    parameter logic [DATA_W-1:0] HALT_OP  = 8'hFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [ADDR_W-1:0] pc_out,
    output logic              pc_en,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_in,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic [DATA_W-1:0] ir_opcode,
    output logic [DATA_W-1:0] ir_operand,
    output logic [ADDR_W-1:0] ir_pc,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    output logic              halted
);

    typedef enum logic [1:0] {
        S_OP   = 2'd0,
        S_ARG  = 2'd1,
        S_HOLD = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              w_ld_op;
    logic              w_ld_arg;
    logic              r_valid;
    logic [DATA_W-1:0] r_opcode;
    logic [DATA_W-1:0] r_operand;
    logic [ADDR_W-1:0] r_pc;

    // The PC module already presents the address of the next byte to read.
    assign mem_addr   = pc_out;
    assign ir_valid   = r_valid;
    assign ir_opcode  = r_opcode;
    assign ir_operand = r_operand;
    assign ir_pc      = r_pc;
    assign halted     = (r_state == S_HALT);

    // Next-state and combinational PC / memory controls; reset then branch take priority.
    always_comb begin
        w_next   = r_state;
        pc_en    = 1'b0;
        pc_load  = 1'b0;
        pc_in    = '0;
        mem_req  = 1'b0;
        w_ld_op  = 1'b0;
        w_ld_arg = 1'b0;
        if (!rst) begin
            w_next = S_OP;
        end else if (br_taken) begin
            // Redirect flushes any partial instruction; a coincident mem_ready
            // is dropped because no load strobe is raised here.
            pc_load = 1'b1;
            pc_in   = br_target;
            w_next  = S_OP;
        end else begin
            case (r_state)
                S_OP: begin
                    mem_req = run;
                    if (run && mem_ready) begin
                        pc_en   = 1'b1;
                        w_ld_op = 1'b1;
                        w_next  = mem_rdata[LONG_BIT] ? S_ARG : S_HOLD;
                    end
                end
                S_ARG: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        pc_en    = 1'b1;
                        w_ld_arg = 1'b1;
                        w_next   = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (ir_ready) begin
                        w_next = (r_opcode == HALT_OP) ? S_HALT : S_OP;
                    end
                end
                S_HALT: begin
                    w_next = S_HALT;
                end
                default: begin
                    w_next = S_OP;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_OP;
        end else begin
            r_state <= w_next;
        end
    end

    // Instruction register: opcode/pc captured with the first byte, operand with the second.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid   <= 1'b0;
            r_opcode  <= '0;
            r_operand <= '0;
            r_pc      <= '0;
        end else begin
            r_valid <= (w_next == S_HOLD);
            if (w_ld_op) begin
                r_opcode  <= mem_rdata;
                r_operand <= '0;
                r_pc      <= pc_out;
            end
            if (w_ld_arg) begin
                r_operand <= mem_rdata;
            end
        end
    end

    // The PC is never asked to increment and load in the same cycle.
    a_no_en_and_load : assert property (@(posedge clk) !(pc_en && pc_load));

    // A presented instruction stays put until the decoder takes it.
    a_ir_stable : assert property (@(posedge clk) disable iff (!rst)
        (ir_valid && !ir_ready && !br_taken) |=>
            (!rst || ($stable(ir_opcode) && $stable(ir_operand) && $stable(ir_pc))));

    // No memory traffic while holding an instruction or halted.
    a_quiet_hold : assert property (@(posedge clk)
        (r_state == S_HOLD || r_state == S_HALT) |-> !mem_req);

endmodule
